// File: rtl/audio_fifo_write_arbiter.sv
// audio_fifo_write_arbiter
//
// Shares the write port of a single-clock show-ahead audio sample FIFO
// between two producers: A (typically the audio-in deserialiser) and
// B (typically the bus-side sample writer). Arbitration is round-robin with
// bursts bounded to BURST_LEN accepted words per grant. The write strobe and
// word toward the FIFO are registered, so the free-space check has to account
// for the one write still in flight when the FIFO full flag is evaluated.
//
// Ports:
//   clk             in   system clock
//   reset           in   asynchronous, active-low reset
//   a_valid/a_data  in   producer A word offer
//   a_ready         out  A word accepted when a_valid is also high
//   b_valid/b_data  in   producer B word offer
//   b_ready         out  B word accepted when b_valid is also high
//   fifo_is_full    in   FIFO full flag
//   words_used      in   FIFO used-word count (reads 0 when full)
//   fifo_write_en   out  registered FIFO write strobe
//   fifo_write_data out  registered FIFO write word
//   grant_a/grant_b out  current grant (both low when idle)
//   almost_full     out  registered words_used >= ALMOST_FULL_LEVEL or full

module audio_fifo_write_arbiter #(
    parameter int DATA_WIDTH        = 32,
    parameter int DATA_DEPTH        = 128,
    parameter int ADDR_WIDTH        = 7,
    parameter int BURST_LEN         = 8,
    parameter int ALMOST_FULL_LEVEL = 96
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  fifo_is_full,
    input  logic [ADDR_WIDTH-1:0] words_used,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    output logic                  grant_a,
    output logic                  grant_b,
    output logic                  almost_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_b_q, last_b_d;   // 1: B held the last grant
    logic [7:0]              beat_q, beat_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    af_q, af_d;

    logic                    space_ok;
    logic                    xfer_a;
    logic                    xfer_b;
    logic [7:0]              beat_inc;
    logic                    burst_done;

    // The registered write issued last cycle has not yet shown up in
    // fifo_is_full; if it is about to take the last slot, refuse this beat.
    assign space_ok = !fifo_is_full &&
                      !(wen_q && (words_used == ADDR_WIDTH'(DATA_DEPTH - 1)));

    assign grant_a = (state_q == GRANT_A);
    assign grant_b = (state_q == GRANT_B);
    assign a_ready = grant_a && space_ok;
    assign b_ready = grant_b && space_ok;
    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;

    assign beat_inc   = beat_q + 8'd1;
    assign burst_done = (beat_inc == 8'(BURST_LEN));

    // Arbitration state machine. A stalled grant (valid high, no space) holds
    // both the grant and the beat count; only a dropped valid or a completed
    // burst releases it.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        beat_d   = beat_q;
        case (state_q)
            IDLE: begin
                if (a_valid && (!b_valid || last_b_q)) begin
                    state_d = GRANT_A;
                end else if (b_valid) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!a_valid || (xfer_a && burst_done)) begin
                    last_b_d = 1'b0;
                    beat_d   = 8'd0;
                    if (b_valid) begin
                        state_d = GRANT_B;
                    end else if (a_valid) begin
                        state_d = GRANT_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer_a) begin
                    beat_d = beat_inc;
                end
            end
            GRANT_B: begin
                if (!b_valid || (xfer_b && burst_done)) begin
                    last_b_d = 1'b1;
                    beat_d   = 8'd0;
                    if (a_valid) begin
                        state_d = GRANT_A;
                    end else if (b_valid) begin
                        state_d = GRANT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer_b) begin
                    beat_d = beat_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write path toward the FIFO; the word holds when nothing is written.
    always_comb begin
        wen_d   = xfer_a || xfer_b;
        wdata_d = wdata_q;
        if (xfer_a) begin
            wdata_d = a_data;
        end else if (xfer_b) begin
            wdata_d = b_data;
        end
        af_d = (32'(words_used) >= 32'(ALMOST_FULL_LEVEL)) || fifo_is_full;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            beat_q   <= 8'd0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            af_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            beat_q   <= beat_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            af_q     <= af_d;
        end
    end

    assign fifo_write_en   = wen_q;
    assign fifo_write_data = wdata_q;
    assign almost_full     = af_q;

endmodule

// File: tb/tb_audio_fifo_write_arbiter.sv
module tb_audio_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        fifo_is_full;
    logic [6:0]  words_used;
    logic        fifo_write_en;
    logic [31:0] fifo_write_data;
    logic        grant_a, grant_b, almost_full;

    int checks   = 0;
    int failures = 0;

    audio_fifo_write_arbiter #(
        .DATA_WIDTH(32), .DATA_DEPTH(128), .ADDR_WIDTH(7),
        .BURST_LEN(8), .ALMOST_FULL_LEVEL(96)
    ) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .fifo_is_full(fifo_is_full), .words_used(words_used),
        .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
        .grant_a(grant_a), .grant_b(grant_b), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
        a_data = '0; b_data = 32'hB0; fifo_is_full = 1'b0; words_used = '0;
        tick(); tick(); #1;
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_wen", fifo_write_en, 0);
        chk("rst_wdata", fifo_write_data, 0);
        chk("rst_af", almost_full, 0);

        // Release: one IDLE cycle, then A wins the tie and bursts 8 words.
        reset = 1'b1; #1;
        chk("idle_after_rst", grant_a, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            a_data = 32'hA0 + i; #1;
            chk("t1_grant_a", grant_a, 1);
            chk("t1_a_ready", a_ready, 1);
            tick();
            chk("t1_wen", fifo_write_en, 1);
            chk("t1_wdata", fifo_write_data, 32'hA0 + i);
        end
        chk("t1_handoff_b", grant_b, 1);
        chk("t1_handoff_a_off", grant_a, 0);
        chk("t1_b_ready", b_ready, 1);

        // Both drop: B exits with no transfer, back to IDLE.
        a_valid = 1'b0; b_valid = 1'b0; #1;
        tick();
        chk("idle_grant_a", grant_a, 0);
        chk("idle_grant_b", grant_b, 0);
        chk("idle_wen", fifo_write_en, 0);
        chk("idle_wdata_hold", fifo_write_data, 32'hA7);

        // Only A valid: 16 back-to-back words across a re-arbitration.
        a_valid = 1'b1; #1;
        tick();
        chk("t2_grant_a", grant_a, 1);
        for (int i = 0; i < 16; i++) begin
            a_data = 32'hC0 + i; #1;
            chk("t2_a_ready", a_ready, 1);
            chk("t2_grant_a_hold", grant_a, 1);
            tick();
            chk("t2_wen", fifo_write_en, 1);
            chk("t2_wdata", fifo_write_data, 32'hC0 + i);
        end

        // Near-full: write in flight with 127 used blocks the accept.
        words_used = 7'd126; a_data = 32'hD0; #1;
        chk("t3_ready_126", a_ready, 1);
        tick();
        chk("t3_wen_d0", fifo_write_en, 1);
        chk("t3_wdata_d0", fifo_write_data, 32'hD0);
        words_used = 7'd127; a_data = 32'hD1; #1;
        chk("t3_inflight_block", a_ready, 0);
        tick();
        chk("t3_no_write", fifo_write_en, 0);
        chk("t3_wdata_hold", fifo_write_data, 32'hD0);
        fifo_is_full = 1'b1; words_used = 7'd0; #1;
        chk("t3_full_ready", a_ready, 0);
        tick();
        chk("t3_full_wen", fifo_write_en, 0);
        chk("t3_full_grant", grant_a, 1);
        #1; tick();
        chk("t3_full_wen2", fifo_write_en, 0);
        // One read frees a slot.
        fifo_is_full = 1'b0; words_used = 7'd127; #1;
        chk("t3_resume_ready", a_ready, 1);
        tick();
        chk("t3_resume_wen", fifo_write_en, 1);
        chk("t3_resume_wdata", fifo_write_data, 32'hD1);
        fifo_is_full = 1'b1; words_used = 7'd0; a_data = 32'hD2; #1;
        chk("t3_full_again", a_ready, 0);
        tick();
        chk("t3_full_again_wen", fifo_write_en, 0);
        // Beat count continues from 2: six more words end the burst.
        fifo_is_full = 1'b0; words_used = 7'd64; b_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 32'hD2 + i; #1;
            chk("t3_tail_grant_a", grant_a, 1);
            chk("t3_tail_ready", a_ready, 1);
            tick();
            chk("t3_tail_wen", fifo_write_en, 1);
            chk("t3_tail_wdata", fifo_write_data, 32'hD2 + i);
        end
        chk("t3_burst_end_b", grant_b, 1);

        // B drops with A waiting: direct handoff to A.
        b_valid = 1'b0; a_valid = 1'b1; words_used = 7'd0; #1;
        tick();
        chk("t4_grant_a", grant_a, 1);
        chk("t4_no_write", fifo_write_en, 0);
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'hE0 + i; #1;
            tick();
            chk("t4_wdata", fifo_write_data, 32'hE0 + i);
        end
        a_valid = 1'b0; #1;
        tick();
        chk("t4_switch_b", grant_b, 1);
        chk("t4_switch_wen", fifo_write_en, 0);
        b_valid = 1'b0; #1;
        tick();
        chk("t4_idle", grant_b, 0);
        a_valid = 1'b1; #1;
        tick();
        chk("t4_grant_a2", grant_a, 1);
        a_data = 32'hE8; #1;
        tick();
        chk("t4_wen_e8", fifo_write_en, 1);
        a_valid = 1'b0; #1;
        tick();
        chk("t4_idle2_a", grant_a, 0);
        chk("t4_idle2_b", grant_b, 0);
        a_valid = 1'b1; b_valid = 1'b1; #1;
        tick();
        chk("t4_tie_to_b", grant_b, 1);
        chk("t4_tie_a_off", grant_a, 0);
        a_valid = 1'b0; b_valid = 1'b0; #1;
        tick();

        // almost_full threshold and latency.
        words_used = 7'd95; #1;
        tick();
        chk("t5_af_95", almost_full, 0);
        words_used = 7'd96; #1;
        chk("t5_af_lag", almost_full, 0);
        tick();
        chk("t5_af_96", almost_full, 1);
        words_used = 7'd95; #1;
        chk("t5_af_fall_lag", almost_full, 1);
        tick();
        chk("t5_af_back_95", almost_full, 0);
        fifo_is_full = 1'b1; words_used = 7'd0; #1;
        tick();
        chk("t5_af_full", almost_full, 1);
        fifo_is_full = 1'b0; #1;
        tick();
        chk("t5_af_clear", almost_full, 0);

        // Reset at beat 5 of an A burst.
        a_valid = 1'b1; #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            a_data = 32'hF0 + i; #1;
            tick();
        end
        chk("t6_pre_wdata", fifo_write_data, 32'hF4);
        b_valid = 1'b1; reset = 1'b0; #1;
        chk("t6_rst_grant_a", grant_a, 0);
        chk("t6_rst_a_ready", a_ready, 0);
        chk("t6_rst_wen", fifo_write_en, 0);
        chk("t6_rst_wdata", fifo_write_data, 0);
        tick();
        reset = 1'b1; #1;
        chk("t6_idle", grant_a, 0);
        tick();
        chk("t6_a_priority", grant_a, 1);
        for (int i = 0; i < 8; i++) begin
            a_data = 32'h100 + i; #1;
            chk("t6_grant_a", grant_a, 1);
            tick();
            chk("t6_wdata", fifo_write_data, 32'h100 + i);
        end
        chk("t6_full_burst_b", grant_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
